limiter_pd_sched: RTL and testbench
===================================

Name: limiter_pd_sched

Overview:
Duty-cycle scheduler for the limiter's power-down (pd) line in the energy-managed sensor node. The CPU programs off, settle and on durations; the block then sequences pd autonomously: off, wake with settle wait, on, then off again. A hardware request input `req` can wake the limiter early and hold it on. A manual mode passes a CPU-written pd bit straight through. The block sits on the CPU peripheral bus beside the limiter.

Parameters:
DATA_W, 32, CPU data width.
CNT_W, 16, width of the timing registers and the down-counter, in clk cycles; CNT_W <= DATA_W.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
valid  in  1  CPU request strobe.
address  in  3  word register index.
wdata  in  DATA_W  write data.
wstrb  in  1  1 = write, 0 = read.
rdata  out  DATA_W  read data, registered.
ready  out  1  acknowledge.
req  in  1  consumer needs the limiter powered; level-sensitive.
pd  out  1  limiter power-down; 1 = powered down.
lim_on  out  1  limiter powered and settled.
irq  out  1  wake interrupt; irq = IRQ_PEND & IRQ_EN.

Behaviour:
- Reset values: all registers 0, state MANUAL, counter 0, ready 0, rdata 0, pd 0, lim_on 0, irq 0.
- Bus handshake:
  - ready <= valid every cycle, giving single-cycle latency.
  - A write takes effect at the clk edge where valid & wstrb are high.
  - A read loads rdata at the same edge, in the cycle ready rises.
  - Unmapped addresses: writes are ignored; reads return 0.
- Register map:
  - 0 CTRL (RW): bit0 AUTO, bit1 MAN_PD, bit2 IRQ_EN.
  - 1 OFF_TIME (RW, CNT_W bits).
  - 2 SETTLE_TIME (RW, CNT_W bits).
  - 3 ON_TIME (RW, CNT_W bits).
  - 4 STATUS: bits[1:0] state (RO: 0 MANUAL, 1 OFF, 2 SETTLE, 3 ON); bit2 lim_on (RO); bit3 IRQ_PEND (write 1 to clear).
  - Upper bits of the timing registers read 0.
- Counter rule: on entering a timed state, the counter loads that state's timing register value N. Each cycle in the state: if counter == 0, transition; otherwise decrement. A timed state therefore lasts N+1 cycles; N = 0 gives 1 cycle.
- Timing-register writes do not affect a running count. The new value is used at the next load.
- FSM transitions:
  - MANUAL: pd = MAN_PD, lim_on = 0. If AUTO = 1, go to OFF and load OFF_TIME.
  - OFF: pd = 1. If req = 1 or counter == 0, go to SETTLE and load SETTLE_TIME. A req-triggered exit happens on the edge where req is sampled high.
  - SETTLE: pd = 0. If counter == 0, go to ON, load ON_TIME, set IRQ_PEND.
  - ON: pd = 0, lim_on = 1. If counter == 0 and req = 0, go to OFF and load OFF_TIME. If counter == 0 and req = 1, hold in ON with counter at 0. The exit occurs on the first cycle req is low.
- Priority:
  - AUTO = 0 in any timed state forces MANUAL on the next edge, overriding all other transitions.
  - A CPU write clearing AUTO takes effect that same edge: state becomes MANUAL, pd = MAN_PD from the new CTRL.
  - An IRQ_PEND set event and a W1C in the same cycle: set wins.
- pd, lim_on and irq are registered outputs, decoded from the next state: glitch-free, and aligned with the state field in STATUS.
- Reset mid-sequence: asynchronous return to MANUAL with pd = 0, so the limiter powers up, matching the limiter's own reset value.

Decomposition:
- Shared package/header `limiter_pd_sched.vh` holds:
  - register addresses: CTRL 0, OFF_TIME 1, SETTLE_TIME 2, ON_TIME 3, STATUS 4;
  - CTRL bit indices;
  - state encodings MANUAL 2'd0, OFF 2'd1, SETTLE 2'd2, ON 2'd3.
- One natural sub-module, `pd_sched_timer`: a CNT_W loadable down-counter with inputs load and load_val, and output zero. The FSM and register file stay in the top module.

Test Plan:
1. Reset → pd = 0, lim_on = 0, irq = 0. Reads of addresses 0–4 all return 0; address 7 returns 0. ready follows valid by 1 cycle.
2. MANUAL: write CTRL = 0x2 → pd = 1 on the next cycle. Write CTRL = 0x0 → pd = 0.
3. Program OFF = 4, SETTLE = 2, ON = 3, then write CTRL = 0x5 → repeating cycle with OFF for 5 cycles (pd = 1), SETTLE for 3 (pd = 0, lim_on = 0), ON for 4 (lim_on = 1). irq rises on entry to ON. Write STATUS = 0x8 → irq drops.
4. In OFF with OFF = 100, pulse req for 1 cycle at OFF cycle 10 → SETTLE entered on the next edge. Hold req high through ON expiry → state stays ON; drop req → OFF on the next edge.
5. Mid-SETTLE, write CTRL = 0x2 → MANUAL on that edge, pd = 1. Assert rst_n low mid-ON → immediately MANUAL, pd = 0, registers 0.
6. Rewrite ON_TIME = 10 while in ON with counter 2 → current ON lasts its original length; the next ON lasts 11 cycles. W1C on STATUS in the same cycle as SETTLE→ON → IRQ_PEND remains 1.

Source files
------------

// File: rtl/limiter_pd_sched_pkg.sv
// limiter_pd_sched_pkg
//   Shared definitions for the limiter power-down scheduler: CPU register
//   addresses, CTRL/STATUS bit positions and the scheduler state encoding.
package limiter_pd_sched_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_OFF     = 3'd1;
    localparam logic [2:0] ADDR_SETTLE  = 3'd2;
    localparam logic [2:0] ADDR_ON      = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;

    localparam int CTRL_AUTO       = 0;
    localparam int CTRL_MAN_PD     = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int STATUS_IRQ_PEND = 3;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_OFF    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ON     = 2'd3
    } state_t;

endpackage

// File: rtl/limiter_pd_sched_if.sv
// limiter_pd_sched_if
//   CPU peripheral bus seen by the scheduler.
//   valid   : request strobe (master -> slave)
//   address : word register index
//   wdata   : write data
//   wstrb   : 1 = write, 0 = read
//   rdata   : registered read data (slave -> master)
//   ready   : acknowledge, one cycle after valid
interface limiter_pd_sched_if #(
    parameter int DATA_W = 32
) ();
    logic              valid;
    logic [2:0]        address;
    logic [DATA_W-1:0] wdata;
    logic              wstrb;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/pd_sched_timer.sv
// pd_sched_timer
//   Loadable down-counter that times each scheduler state.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : duration value N; the state then lasts N+1 cycles
//   zero       : counter currently at 0
//   The counter stops at 0 so ON can be held while req stays high.
module pd_sched_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/limiter_pd_sched.sv
// limiter_pd_sched
//   Duty-cycle scheduler for the limiter power-down line. Sequences
//   OFF -> SETTLE -> ON -> OFF from CPU-programmed durations, lets req wake
//   the limiter early and hold it on, and offers a manual pass-through mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : CPU register bus (slave side)
//   req        : consumer needs the limiter powered (level)
//   pd         : limiter power-down, 1 = powered down (registered)
//   lim_on     : limiter powered and settled (registered)
//   irq        : wake interrupt, IRQ_PEND & IRQ_EN (registered)
module limiter_pd_sched
    import limiter_pd_sched_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    limiter_pd_sched_if.slave  bus,
    input  logic               req,
    output logic               pd,
    output logic               lim_on,
    output logic               irq
);

    logic [2:0]       ctrl;
    logic [CNT_W-1:0] off_time;
    logic [CNT_W-1:0] settle_time;
    logic [CNT_W-1:0] on_time;
    logic             irq_pend;
    state_t           state;
    state_t           state_nxt;

    logic             wr_en;
    logic             rd_en;
    logic [2:0]       ctrl_nxt;
    logic             w1c;
    logic             irq_pend_nxt;
    logic             pd_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic [DATA_W-1:0] rd_val;
    logic             unused_wdata;

    assign wr_en = bus.valid & bus.wstrb;
    assign rd_en = bus.valid & ~bus.wstrb;
    assign w1c   = wr_en && (bus.address == ADDR_STATUS) && bus.wdata[STATUS_IRQ_PEND];
    assign unused_wdata = ^bus.wdata;

    // The FSM sees CTRL as it will be after this edge, so a CPU write to
    // AUTO or MAN_PD acts on the same edge it is written.
    assign ctrl_nxt = (wr_en && (bus.address == ADDR_CTRL)) ? bus.wdata[2:0] : ctrl;

    pd_sched_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_MANUAL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, timer load and next-state output decode
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        pd_nxt    = 1'b0;
        if (state != ST_MANUAL && !ctrl_nxt[CTRL_AUTO]) begin
            state_nxt = ST_MANUAL;
        end else begin
            case (state)
                ST_MANUAL: begin
                    if (ctrl_nxt[CTRL_AUTO]) begin
                        state_nxt = ST_OFF;
                        tmr_load  = 1'b1;
                        tmr_val   = off_time;
                    end
                end
                ST_OFF: begin
                    if (req || tmr_zero) begin
                        state_nxt = ST_SETTLE;
                        tmr_load  = 1'b1;
                        tmr_val   = settle_time;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        state_nxt = ST_ON;
                        tmr_load  = 1'b1;
                        tmr_val   = on_time;
                    end
                end
                ST_ON: begin
                    if (tmr_zero && !req) begin
                        state_nxt = ST_OFF;
                        tmr_load  = 1'b1;
                        tmr_val   = off_time;
                    end
                end
                default: state_nxt = ST_MANUAL;
            endcase
        end
        case (state_nxt)
            ST_MANUAL: pd_nxt = ctrl_nxt[CTRL_MAN_PD];
            ST_OFF:    pd_nxt = 1'b1;
            default:   pd_nxt = 1'b0;
        endcase
    end

    // A set event on SETTLE -> ON beats a simultaneous W1C.
    assign irq_pend_nxt = ((state == ST_SETTLE) && (state_nxt == ST_ON)) | (irq_pend & ~w1c);

    always_comb begin
        rd_val = '0;
        case (bus.address)
            ADDR_CTRL:   rd_val[2:0]       = ctrl;
            ADDR_OFF:    rd_val[CNT_W-1:0] = off_time;
            ADDR_SETTLE: rd_val[CNT_W-1:0] = settle_time;
            ADDR_ON:     rd_val[CNT_W-1:0] = on_time;
            ADDR_STATUS: rd_val[3:0]       = {irq_pend, lim_on, state};
            default:     rd_val            = '0;
        endcase
    end

    // Register file, bus response and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl        <= '0;
            off_time    <= '0;
            settle_time <= '0;
            on_time     <= '0;
            irq_pend    <= 1'b0;
            bus.ready   <= 1'b0;
            bus.rdata   <= '0;
            pd          <= 1'b0;
            lim_on      <= 1'b0;
            irq         <= 1'b0;
        end else begin
            bus.ready <= bus.valid;
            if (rd_en) begin
                bus.rdata <= rd_val;
            end
            ctrl <= ctrl_nxt;
            if (wr_en) begin
                case (bus.address)
                    ADDR_OFF:    off_time    <= bus.wdata[CNT_W-1:0];
                    ADDR_SETTLE: settle_time <= bus.wdata[CNT_W-1:0];
                    ADDR_ON:     on_time     <= bus.wdata[CNT_W-1:0];
                    default: ;
                endcase
            end
            irq_pend <= irq_pend_nxt;
            pd       <= pd_nxt;
            lim_on   <= (state_nxt == ST_ON);
            irq      <= irq_pend_nxt & ctrl_nxt[CTRL_IRQ_EN];
        end
    end

endmodule

// File: tb/tb_limiter_pd_sched.sv
module tb_limiter_pd_sched;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic pd, lim_on, irq;

    limiter_pd_sched_if #(.DATA_W(DATA_W)) bus ();

    limiter_pd_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .req    (req),
        .pd     (pd),
        .lim_on (lim_on),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pd;
        logic        lim_on;
        logic        irq;
        logic        ready;
        logic        chk_rd;
        logic [31:0] rdata;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: phase 0 MANUAL, 1 OFF, 2 SETTLE, 3 ON.
    // Each timed phase has a length dur (cycles) and el cycles already spent.
    int          m_phase = 0;
    int          m_el    = 0;
    int          m_dur   = 1;
    logic [2:0]  m_ctrl  = '0;
    int          m_off   = 0;
    int          m_set   = 0;
    int          m_on    = 0;
    logic        m_pend  = 1'b0;

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, n, act, want);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [1:0] ph;
        ph = 2'(m_phase);
        case (a)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return 32'(m_off);
            3'd2: return 32'(m_set);
            3'd3: return 32'(m_on);
            3'd4: return {28'd0, m_pend, (m_phase == 3), ph};
            default: return 32'd0;
        endcase
    endfunction

    task automatic enter(input int ph, input int n);
        m_phase = ph;
        m_el    = 0;
        m_dur   = n + 1;
    endtask

    task automatic model_reset();
        m_phase = 0; m_el = 0; m_dur = 1;
        m_ctrl = '0; m_off = 0; m_set = 0; m_on = 0; m_pend = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, queue the expected outputs.
    task automatic step(input logic v, input logic [2:0] a, input logic [31:0] wd,
                        input logic we, input logic rq);
        exp_t e;
        logic [2:0] nc;
        logic w1c, set, last;
        bus.valid = v; bus.address = a; bus.wdata = wd; bus.wstrb = we; req = rq;
        e.ready  = v;
        e.chk_rd = v && !we;
        e.rdata  = m_read(a);
        e.n      = n_vec;
        nc   = (v && we && a == 3'd0) ? wd[2:0] : m_ctrl;
        w1c  = v && we && a == 3'd4 && wd[3];
        set  = 1'b0;
        last = (m_el + 1 >= m_dur);
        if (m_phase != 0 && !nc[0]) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (nc[0]) enter(1, m_off);
                1: if (rq || last) enter(2, m_set); else m_el++;
                2: if (last) begin enter(3, m_on); set = 1'b1; end else m_el++;
                default: if (last) begin if (!rq) enter(1, m_off); end else m_el++;
            endcase
        end
        m_pend = set | (m_pend & !w1c);
        m_ctrl = nc;
        if (v && we) begin
            case (a)
                3'd1: m_off = int'(wd[15:0]);
                3'd2: m_set = int'(wd[15:0]);
                3'd3: m_on  = int'(wd[15:0]);
                default: ;
            endcase
        end
        e.pd     = (m_phase == 0) ? m_ctrl[1] : (m_phase == 1);
        e.lim_on = (m_phase == 3);
        e.irq    = m_pend & m_ctrl[2];
        n_vec++;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rq);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 1'b0, rq);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b1, req);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, a, 32'd0, 1'b0, req);
    endtask

    task automatic wait_phase(input int ph, input int lim);
        int k;
        k = 0;
        while (m_phase != ph && k < lim) begin
            idle(1, req);
            k++;
        end
        if (m_phase != ph) begin
            n_err++;
            $display("FAIL wait_phase: phase %0d, expected %0d within %0d cycles", m_phase, ph, lim);
        end
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, ".pd"},     n_vec, {31'd0, pd},        32'd0);
        chk({nm, ".lim_on"}, n_vec, {31'd0, lim_on},    32'd0);
        chk({nm, ".irq"},    n_vec, {31'd0, irq},       32'd0);
        chk({nm, ".ready"},  n_vec, {31'd0, bus.ready}, 32'd0);
        chk({nm, ".rdata"},  n_vec, bus.rdata,          32'd0);
    endtask

    // Asynchronous reset in the low half of the clock; the scoreboard is empty here.
    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        bus.valid = 1'b0;
        req = 1'b0;
        #1;
        check_reset_state("mid_reset");
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("pd",     me.n, {31'd0, pd},        {31'd0, me.pd});
            chk("lim_on", me.n, {31'd0, lim_on},    {31'd0, me.lim_on});
            chk("irq",    me.n, {31'd0, irq},       {31'd0, me.irq});
            chk("ready",  me.n, {31'd0, bus.ready}, {31'd0, me.ready});
            if (me.chk_rd) chk("rdata", me.n, bus.rdata, me.rdata);
        end
    end

    initial begin
        logic [2:0] addrs [6];
        int r;
        addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        #1;
        rst_n = 1'b1;

        // Reset register contents and ready latency
        foreach (addrs[i]) rd(addrs[i]);
        idle(2, 1'b0);

        // Manual pass-through
        wr(3'd0, 32'h2);
        idle(2, 1'b0);
        wr(3'd0, 32'h0);
        idle(2, 1'b0);

        // Autonomous cycle OFF=4 SETTLE=2 ON=3 with irq, then W1C
        wr(3'd1, 32'd4);
        wr(3'd2, 32'd2);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'h5);
        for (int i = 0; i < 30; i++) begin
            if (i % 7 == 3) rd(3'd4); else idle(1, 1'b0);
        end
        wr(3'd4, 32'h8);
        idle(3, 1'b0);

        // Early wake by req pulse, then hold ON with req
        wr(3'd0, 32'h0);
        wr(3'd1, 32'd100);
        wr(3'd0, 32'h5);
        idle(10, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        wait_phase(3, 20);
        idle(12, 1'b1);
        idle(4, 1'b0);

        // Manual override mid-SETTLE, then async reset mid-ON
        wr(3'd1, 32'd4);
        wait_phase(2, 200);
        wr(3'd0, 32'h2);
        idle(2, 1'b0);
        wr(3'd0, 32'h5);
        wait_phase(3, 40);
        idle(1, 1'b0);
        async_reset();
        foreach (addrs[i]) rd(addrs[i]);

        // ON_TIME rewrite during a running ON, and W1C racing SETTLE -> ON
        wr(3'd1, 32'd3);
        wr(3'd2, 32'd2);
        wr(3'd3, 32'd5);
        wr(3'd0, 32'h5);
        wait_phase(3, 40);
        while (m_phase == 3 && (m_dur - m_el - 1) != 2) idle(1, 1'b0);
        wr(3'd3, 32'hABCD_000A);
        idle(30, 1'b0);
        wait_phase(2, 40);
        while (m_phase == 2 && (m_el + 1 < m_dur)) idle(1, 1'b0);
        wr(3'd4, 32'h8);
        rd(3'd4);
        idle(2, 1'b0);
        rd(3'd3);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic rq;
            rq = ($urandom_range(0, 3) == 0) ? ~req : req;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: step(1'b0, 3'd0, 32'd0, 1'b0, rq);
                4, 5: step(1'b1, 3'($urandom_range(0, 7)), $urandom, 1'b0, rq);
                6: step(1'b1, 3'($urandom_range(1, 3)),
                        {16'($urandom), 16'($urandom_range(0, 5))}, 1'b1, rq);
                7: step(1'b1, 3'd0, {$urandom_range(0, 1) == 0 ? 29'd0 : 29'($urandom),
                        2'($urandom), ($urandom_range(0, 7) != 0)}, 1'b1, rq);
                8: step(1'b1, 3'd4, $urandom, 1'b1, rq);
                default: step(1'b1, 3'($urandom_range(5, 7)), $urandom, 1'b1, rq);
            endcase
        end
        idle(2, 1'b0);

        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected responses left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
